dispatch_ctrl: RTL

- Instruction queue and dispatch scheduler between ifetch and the decoder.
- Buffers fetched instructions in a circular FIFO and presents at most one instruction per cycle to the decoder.
- Dispatches only when the ROB and the target station (RS for non-memory ops, LSB for load/store) have space.
- Flushes on rollback and keeps saturating dispatch/stall counters for performance analysis.

---
 rtl/dispatch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: instruction queue between ifetch and the decoder.
// Holds fetched instructions in an 8-entry circular FIFO and hands the head
// entry to the decoder when the ROB and the target station (RS or LSB) have
// room. A rollback empties the queue and inserts a one-cycle FLUSH window so
// the wrong-path instruction still in flight from ifetch is discarded.
module dispatch_ctrl #(
    parameter int IQ_DEPTH_LOG = 3,
    parameter int INST_W       = 32,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_predict_jump,
    output logic              iq_full,
    input  logic              rob_full,
    input  logic              rs_full,
    input  logic              lsb_full,
    output logic              dec_valid,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              dec_predict_jump,
    output logic [31:0]       dispatch_cnt,
    output logic [31:0]       stall_cnt
);

    localparam int DEPTH   = 1 << IQ_DEPTH_LOG;
    localparam int COUNT_W = IQ_DEPTH_LOG + 1;
    // iq_full is raised one entry early so the instruction ifetch already
    // has in flight still finds a free slot.
    localparam logic [COUNT_W-1:0] FULL_MARK = COUNT_W'(DEPTH - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                  state;
    logic [IQ_DEPTH_LOG-1:0] head;
    logic [IQ_DEPTH_LOG-1:0] tail;
    logic [COUNT_W-1:0]      count;
    logic [COUNT_W-1:0]      count_next;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              pj_mem   [DEPTH];

    logic not_empty;
    logic at_capacity;
    logic to_lsb;
    logic target_full;
    logic disp;
    logic enq;
    logic stall;

    // Loads and stores go to the load/store buffer, everything else to the RS.
    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == 7'b0000011) || (opcode == 7'b0100011);
    endfunction

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    assign not_empty   = (count != '0);
    // count never exceeds DEPTH, so its top bit alone marks a full queue.
    assign at_capacity = count[IQ_DEPTH_LOG];
    assign to_lsb      = is_mem_op(inst_mem[head][6:0]);
    assign target_full = to_lsb ? lsb_full : rs_full;

    assign disp  = rdy && !rollback && (state == RUN) && not_empty
                   && !rob_full && !target_full;
    assign enq   = if_valid && rdy && !rollback && (state == RUN) && !at_capacity;
    assign stall = rdy && (state == RUN) && not_empty && !disp && !rollback;

    // Zero-latency handoff: the decoder sees the head entry combinationally.
    assign dec_valid        = disp;
    assign dec_inst         = not_empty ? inst_mem[head] : '0;
    assign dec_pc           = not_empty ? pc_mem[head]   : '0;
    assign dec_predict_jump = not_empty ? pj_mem[head]   : 1'b0;

    // Occupancy after this cycle's enqueue/dispatch pair.
    always_comb begin
        count_next = count;
        unique case ({enq, disp})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Queue storage; written only on an accepted enqueue, no reset needed.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail] <= if_inst;
            pc_mem[tail]   <= if_pc;
            pj_mem[tail]   <= if_predict_jump;
        end
    end

    // Control FSM, pointers, occupancy, full flag and performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            iq_full      <= 1'b0;
            dispatch_cnt <= '0;
            stall_cnt    <= '0;
        end else if (rdy) begin
            if (rollback) begin
                state   <= FLUSH;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                iq_full <= 1'b0;
            end else begin
                state   <= RUN;
                if (enq)
                    tail <= tail + 1'b1;
                if (disp)
                    head <= head + 1'b1;
                count   <= count_next;
                iq_full <= (count_next >= FULL_MARK);
            end
            if (disp)
                dispatch_cnt <= sat_inc(dispatch_cnt);
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
